mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Sequencer that drives the operand side of the `MAC` dot-product unit. It fetches N-element operand vectors from two synchronous-read operand RAMs and issues them as bursts on the `sof`/`A`/`B` interface that `MAC` consumes. It can chain up to 255 dot products, such as one row of A against successive columns of B. After each burst it flags the cycle in which the MAC accumulator holds the final sum, so a result collector can capture it.

## Interface
- `N`, 12: elements per dot product. Must equal the MAC `N`.
- `WIDTH`, 16: operand width.
- `PIPE`, 3: MAC `sof` length and multiplier latency. Must equal the MAC `PIPE`. Legal range is 1 ≤ PIPE ≤ N.
- `ADDR_W`, 8: operand RAM address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request. Sampled only in IDLE.
- `a_base` input ADDR_W: address of A element 0. Latched on start.
- `b_base` input ADDR_W: address of B element 0 for job 0. Latched on start.
- `a_stride` input ADDR_W: A address increment per element. Latched on start.
- `b_stride` input ADDR_W: B address increment per element. Latched on start.
- `b_job_step` input ADDR_W: B base increment per job. Latched on start.
- `num_jobs` input 8: number of dot products. Latched on start.
- `a_rd_en`, `b_rd_en` output 1: RAM read strobes.
- `a_addr`, `b_addr` output ADDR_W: RAM read addresses.
- `a_rdata`, `b_rdata` input WIDTH: RAM data, valid 1 cycle after the read strobe.
- `sof` output 1: MAC start-of-frame.
- `A`, `B` output WIDTH: MAC operands.
- `c_valid` output 1: one-cycle pulse; the MAC `C` is final this cycle.
- `busy` output 1: high from the cycle after an accepted start until done.
- `done` output 1: one-cycle pulse after the last job.

## Operation
- States: IDLE, PREFETCH, STREAM, DRAIN.
- **IDLE:** on `start` with `num_jobs` ≠ 0, latch all inputs, clear the job counter, and go to PREFETCH.
  - On `start` with `num_jobs` = 0, pulse `done` next cycle. No reads and no bursts.
- **PREFETCH** (1 cycle): assert both read strobes for element k=0.
  - `a_addr` = a_base_l.
  - `b_addr` = b_cur, the latched B base plus job × b_job_step.
  - Go to STREAM.
- **STREAM** (N cycles, element index e = 0..N-1):
  - `A`/`B` present the RAM data for element e.
  - While e < N-1, read element e+1: `a_addr` = a_base_l + (e+1)·a_stride, `b_addr` = b_cur + (e+1)·b_stride.
  - `sof` = 1 for e < PIPE, else 0.
  - After e = N-1, go to DRAIN.
- **DRAIN** (PIPE cycles): `A` = `B` = 0, `sof` = 0, no reads. On the last DRAIN cycle:
  - If jobs remain: increment the job counter, update b_cur += b_job_step, and go to PREFETCH.
  - Otherwise: go to IDLE.
- `c_valid` pulses the cycle after each job's last DRAIN cycle.
  - For the final job, `done` pulses in the same cycle as `c_valid`, and `busy` falls in that cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Outside STREAM, `A`, `B` and `sof` are 0. The MAC therefore never sees a spurious `sof`.
- `start` while busy is ignored and does not change the latched values.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Reset mid-operation aborts immediately: no `c_valid`, no `done`, read strobes drop.
- Cycle numbering: `start` is sampled at cycle s.
  - PREFETCH is at s+1.
  - First data and the first `sof` are at t0 = s+2.
  - `sof` is high for cycles t0..t0+PIPE-1, so the MAC enters its MAC state at t0+PIPE.
  - STREAM occupies t0..t0+N-1.
  - DRAIN occupies t0+N..t0+N+PIPE-1.
  - `c_valid` fires at t0+N+PIPE, when the MAC `C` has absorbed all N products.
- Job period is N+PIPE+1 cycles. The next job's PREFETCH coincides with the previous job's `c_valid`.
- Total latency from `start` to `done` is 1 + num_jobs·(N+PIPE+1) cycles. For the defaults this is 1 + 16·num_jobs.
- Operands are registered outputs. RAM data passes through one register stage only; the feeder drives the RAM read one cycle ahead, so `A`/`B` line up with `sof`.
- The feeder never clears the MAC accumulator. The system clears or subtracts C between jobs.

## Test plan
- **Single job:** defaults, a_base=0, a_stride=1, b_base=0x40, b_stride=12, num_jobs=1, RAMs preloaded with A[k]=k+1 and B[k]=2.
  - `sof` is high for exactly 3 cycles starting at s+2.
  - A reads 1..12 on consecutive cycles.
  - `c_valid` and `done` fire at s+17.
  - A MAC instance connected to the feeder reads C=156.
- **Chained jobs:** num_jobs=3, b_job_step=1.
  - b_addr bases are 0x40, 0x41, 0x42.
  - `c_valid` fires at s+17, s+33, s+49.
  - `done` fires only at s+49.
  - `sof` never overlaps the MAC state of the previous job.
- **Zero jobs:** num_jobs=0.
  - `done` fires at s+1.
  - `busy`, `sof`, `c_valid` and both read strobes stay 0.
- **Address wrap:** a_base=0xFE, a_stride=1.
  - a_addr sequence is 0xFE, 0xFF, 0x00, …, 0x09.
- **Start while busy:** `start` with changed bases at t0+4.
  - The current job is unaffected, no extra job runs, and `done` timing is unchanged.
- **Reset mid-burst:** assert `rst` at t0+5.
  - All outputs are 0 asynchronously.
  - No `c_valid` appears.
  - A new `start` after release runs a clean job with identical timing.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for the MAC dot-product unit: fetches N-element vectors from two
// synchronous-read RAMs and issues sof/A/B bursts, chaining up to 255 dot products.
module mac_operand_feeder #(
    parameter int N      = 12,
    parameter int WIDTH  = 16,
    parameter int PIPE   = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] a_stride,
    input  logic [ADDR_W-1:0] b_stride,
    input  logic [ADDR_W-1:0] b_job_step,
    input  logic [7:0]        num_jobs,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  a_rdata,
    input  logic [WIDTH-1:0]  b_rdata,
    output logic              sof,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              c_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DRAIN} state_t;

    localparam int EW = $clog2(N + 1);
    localparam int DW = $clog2(PIPE + 1);
    localparam logic [EW-1:0] LAST_E = EW'(N - 1);
    localparam logic [EW-1:0] PIPE_E = EW'(PIPE);
    localparam logic [DW-1:0] LAST_D = DW'(PIPE - 1);

    state_t            state;
    logic [EW-1:0]     elem;
    logic [EW-1:0]     elem_nx;
    logic [DW-1:0]     drain;
    logic [7:0]        job;
    logic [7:0]        num_jobs_l;
    logic [ADDR_W-1:0] a_base_l;
    logic [ADDR_W-1:0] a_stride_l;
    logic [ADDR_W-1:0] b_stride_l;
    logic [ADDR_W-1:0] b_step_l;
    logic [ADDR_W-1:0] b_cur;
    logic              stream_q;

    assign elem_nx = elem + EW'(1);

    // The RAM output register is the single data stage; gating it with a registered
    // flag keeps A/B aligned with sof and forces them to 0 outside STREAM.
    assign A = stream_q ? a_rdata : '0;
    assign B = stream_q ? b_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            elem       <= '0;
            drain      <= '0;
            job        <= '0;
            num_jobs_l <= '0;
            a_base_l   <= '0;
            a_stride_l <= '0;
            b_stride_l <= '0;
            b_step_l   <= '0;
            b_cur      <= '0;
            stream_q   <= 1'b0;
            a_rd_en    <= 1'b0;
            b_rd_en    <= 1'b0;
            a_addr     <= '0;
            b_addr     <= '0;
            sof        <= 1'b0;
            c_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make c_valid/done single-cycle pulses; any
            // branch below that assigns them later in this block overrides the default.
            c_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_jobs != 8'd0) begin
                            num_jobs_l <= num_jobs;
                            a_base_l   <= a_base;
                            a_stride_l <= a_stride;
                            b_stride_l <= b_stride;
                            b_step_l   <= b_job_step;
                            b_cur      <= b_base;
                            job        <= '0;
                            a_addr     <= a_base;
                            b_addr     <= b_base;
                            a_rd_en    <= 1'b1;
                            b_rd_en    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= PREFETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                PREFETCH: begin
                    elem     <= '0;
                    stream_q <= 1'b1;
                    sof      <= 1'b1;
                    a_rd_en  <= (LAST_E != '0);
                    b_rd_en  <= (LAST_E != '0);
                    a_addr   <= a_addr + a_stride_l;
                    b_addr   <= b_addr + b_stride_l;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (elem == LAST_E) begin
                        stream_q <= 1'b0;
                        sof      <= 1'b0;
                        a_rd_en  <= 1'b0;
                        b_rd_en  <= 1'b0;
                        drain    <= '0;
                        state    <= DRAIN;
                    end else begin
                        // Address registers always run one element ahead of the data.
                        elem    <= elem_nx;
                        sof     <= (elem_nx < PIPE_E);
                        a_rd_en <= (elem_nx < LAST_E);
                        b_rd_en <= (elem_nx < LAST_E);
                        a_addr  <= a_addr + a_stride_l;
                        b_addr  <= b_addr + b_stride_l;
                    end
                end
                DRAIN: begin
                    if (drain == LAST_D) begin
                        c_valid <= 1'b1;
                        if (job == num_jobs_l - 8'd1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            job     <= job + 8'd1;
                            b_cur   <= b_cur + b_step_l;
                            a_addr  <= a_base_l;
                            b_addr  <= b_cur + b_step_l;
                            a_rd_en <= 1'b1;
                            b_rd_en <= 1'b1;
                            state   <= PREFETCH;
                        end
                    end else begin
                        drain <= drain + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder: a spec-level job model pushes expected reads,
// operands, sof cycles, MAC sums and done cycles; a negedge monitor pops and compares.
module tb_mac_operand_feeder;

    localparam int N = 12, WIDTH = 16, PIPE = 3, ADDR_W = 8;
    localparam int P = N + PIPE + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] a_base = '0, b_base = '0, a_stride = '0, b_stride = '0, b_job_step = '0;
    logic [7:0]        num_jobs = '0;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [WIDTH-1:0]  a_rdata = '0, b_rdata = '0;
    logic              sof, c_valid, busy, done;
    logic [WIDTH-1:0]  A, B;

    mac_operand_feeder #(.N(N), .WIDTH(WIDTH), .PIPE(PIPE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_base(a_base), .b_base(b_base), .a_stride(a_stride), .b_stride(b_stride),
        .b_job_step(b_job_step), .num_jobs(num_jobs),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .sof(sof), .A(A), .B(B), .c_valid(c_valid), .busy(busy), .done(done)
    );

    typedef struct { int cyc; logic [7:0] a; logic [7:0] b; } rd_t;
    typedef struct { int cyc; logic [15:0] a; logic [15:0] b; } dat_t;
    typedef struct { int cyc; longint sum; } cv_t;

    rd_t  rd_q[$];
    dat_t dat_q[$];
    cv_t  cv_q[$];
    int   sof_q[$];
    int   done_q[$];

    logic [WIDTH-1:0] ram_a [256];
    logic [WIDTH-1:0] ram_b [256];

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     busy_from = 0, busy_to = 0;
    longint acc = 0;
    longint last_c = -1;
    int     last_cv_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= ram_a[a_addr];
        if (b_rd_en) b_rdata <= ram_b[b_addr];
    end

    // Spec model of one start: job j has PREFETCH at s+1+j*P, data at +1..+N, c_valid at +N+PIPE+1.
    task automatic push_job(input int s, input logic [7:0] ab, input logic [7:0] as_,
                            input logic [7:0] bb, input logic [7:0] bs, input logic [7:0] step,
                            input int nj);
        rd_t r; dat_t d; cv_t c;
        for (int j = 0; j < nj; j++) begin
            int tj = s + 1 + j * P;
            longint sum = 0;
            for (int k = 0; k < N; k++) begin
                logic [7:0] aa, bk;
                aa = 8'(int'(ab) + int'(as_) * k);
                bk = 8'(int'(bb) + int'(step) * j + int'(bs) * k);
                r.cyc = tj + k; r.a = aa; r.b = bk;
                rd_q.push_back(r);
                d.cyc = tj + 1 + k; d.a = ram_a[aa]; d.b = ram_b[bk];
                dat_q.push_back(d);
                sum += longint'(ram_a[aa]) * longint'(ram_b[bk]);
                if (k < PIPE) sof_q.push_back(tj + 1 + k);
            end
            c.cyc = tj + N + PIPE + 1; c.sum = sum;
            cv_q.push_back(c);
        end
        done_q.push_back(s + 1 + nj * P);
        busy_from = (nj == 0) ? 0 : s + 1;
        busy_to   = (nj == 0) ? 0 : s + 1 + nj * P;
    endtask

    task automatic go(input logic [7:0] ab, input logic [7:0] as_, input logic [7:0] bb,
                      input logic [7:0] bs, input logic [7:0] step, input int nj, output int s);
        @(negedge clk);
        a_base = ab; a_stride = as_; b_base = bb; b_stride = bs; b_job_step = step;
        num_jobs = 8'(nj); start = 1'b1;
        s = cyc;
        push_job(s, ab, as_, bb, bs, step, nj);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_drained(input string name);
        int left;
        left = rd_q.size() + dat_q.size() + cv_q.size() + sof_q.size() + done_q.size();
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL %s_missing_events got %0d pending (rd %0d dat %0d cv %0d sof %0d done %0d) expected 0",
                     name, left, rd_q.size(), dat_q.size(), cv_q.size(), sof_q.size(), done_q.size());
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every DUT event.
    initial begin
        rd_t r; dat_t d; cv_t c; int t; logic exp_busy;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (a_rd_en || b_rd_en) begin
                    checks++;
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL read_unexpected cyc=%0d got a_addr=%h b_addr=%h expected no read", cyc, a_addr, b_addr);
                    end else begin
                        r = rd_q.pop_front();
                        if (r.cyc !== cyc || a_addr !== r.a || b_addr !== r.b || a_rd_en !== 1'b1 || b_rd_en !== 1'b1) begin
                            errors++;
                            $display("FAIL read cyc=%0d got en=%b%b a=%h b=%h expected cyc=%0d en=11 a=%h b=%h",
                                     cyc, a_rd_en, b_rd_en, a_addr, b_addr, r.cyc, r.a, r.b);
                        end
                    end
                end
                if (sof) begin
                    checks++;
                    t = (sof_q.size() == 0) ? -1 : sof_q.pop_front();
                    if (t !== cyc) begin
                        errors++;
                        $display("FAIL sof got high at cyc=%0d expected next sof at %0d", cyc, t);
                    end
                end
                checks++;
                if (dat_q.size() != 0 && dat_q[0].cyc == cyc) begin
                    d = dat_q.pop_front();
                    if (A !== d.a || B !== d.b) begin
                        errors++;
                        $display("FAIL operand cyc=%0d got A=%0d B=%0d expected A=%0d B=%0d", cyc, A, B, d.a, d.b);
                    end
                end else if (A !== '0 || B !== '0) begin
                    errors++;
                    $display("FAIL operand_idle cyc=%0d got A=%0d B=%0d expected 0 0", cyc, A, B);
                end
                acc += longint'(A) * longint'(B);
                if (c_valid) begin
                    checks++;
                    last_c = acc; last_cv_cyc = cyc;
                    if (cv_q.size() == 0) begin
                        errors++;
                        $display("FAIL c_valid_unexpected cyc=%0d got sum=%0d expected no c_valid", cyc, acc);
                    end else begin
                        c = cv_q.pop_front();
                        if (c.cyc !== cyc || acc !== c.sum) begin
                            errors++;
                            $display("FAIL c_valid got cyc=%0d sum=%0d expected cyc=%0d sum=%0d", cyc, acc, c.cyc, c.sum);
                        end
                    end
                    acc = 0;
                end
                if (done) begin
                    checks++;
                    t = (done_q.size() == 0) ? -1 : done_q.pop_front();
                    if (t !== cyc) begin
                        errors++;
                        $display("FAIL done got pulse at cyc=%0d expected at %0d", cyc, t);
                    end
                end
                checks++;
                exp_busy = (cyc >= busy_from && cyc < busy_to);
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        checks++;
        if ({a_rd_en, b_rd_en, a_addr, b_addr, sof, A, B, c_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL %s got rd=%b%b a=%h b=%h sof=%b A=%0d B=%0d cv=%b busy=%b done=%b expected all 0",
                     name, a_rd_en, b_rd_en, a_addr, b_addr, sof, A, B, c_valid, busy, done);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("idle_outputs");
    endtask

    task automatic test_single_job;
        int s;
        go(8'h00, 8'd1, 8'h40, 8'd12, 8'd0, 1, s);
        wait_until(s + 1 + P + 2);
        expect_drained("single_job");
        checks++;
        if (last_c !== 156 || last_cv_cyc !== s + 17) begin
            errors++;
            $display("FAIL single_job_C got C=%0d at cyc=%0d expected C=156 at %0d", last_c, last_cv_cyc, s + 17);
        end
    endtask

    task automatic test_chained;
        int s;
        go(8'h00, 8'd1, 8'h40, 8'd12, 8'd1, 3, s);
        wait_until(s + 1 + 3 * P + 2);
        expect_drained("chained");
        checks++;
        if (last_cv_cyc !== s + 49) begin
            errors++;
            $display("FAIL chained_last_c_valid got cyc=%0d expected %0d", last_cv_cyc, s + 49);
        end
    endtask

    task automatic test_zero_jobs;
        int s;
        go(8'h10, 8'd1, 8'h20, 8'd1, 8'd0, 0, s);
        wait_until(s + 6);
        expect_drained("zero_jobs");
    endtask

    task automatic test_wrap;
        int s;
        go(8'hFE, 8'd1, 8'hF8, 8'd3, 8'd0, 1, s);
        wait_until(s + 1 + P + 2);
        expect_drained("wrap");
    endtask

    task automatic test_start_while_busy;
        int s;
        go(8'h00, 8'd1, 8'h40, 8'd12, 8'd0, 1, s);
        wait_until(s + 6);
        a_base = 8'h80; b_base = 8'h10; a_stride = 8'd2; num_jobs = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(s + 1 + P + 6);
        expect_drained("start_while_busy");
    endtask

    task automatic test_reset_mid_burst;
        int s;
        go(8'h00, 8'd1, 8'h40, 8'd12, 8'd0, 1, s);
        wait_until(s + 7);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_async");
        rd_q.delete(); dat_q.delete(); cv_q.delete(); sof_q.delete(); done_q.delete();
        busy_from = 0; busy_to = 0; acc = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        go(8'h00, 8'd1, 8'h40, 8'd12, 8'd0, 1, s);
        wait_until(s + 1 + P + 2);
        expect_drained("reset_recovery");
        checks++;
        if (last_c !== 156 || last_cv_cyc !== s + 17) begin
            errors++;
            $display("FAIL reset_recovery_C got C=%0d at cyc=%0d expected C=156 at %0d", last_c, last_cv_cyc, s + 17);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 16'(i + 1);
            ram_b[i] = 16'((i * 3) % 11 + 1);
        end
        for (int k = 0; k < N; k++) ram_b[8'h40 + 12 * k] = 16'd2;
        test_reset();
        test_single_job();
        test_chained();
        test_zero_jobs();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
